// File: rtl/banner_pkg.sv
// Shared constants and slot FSM encoding for the seven-segment banner scan controller.
package banner_pkg;

    localparam int DIGIT_W = 4;
    localparam int ENTRY_W = 5;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_t;

    // {dp, bcd}: decimal point off (active-low), digit 0
    localparam logic [ENTRY_W-1:0] BLANK_ENTRY = {1'b1, 4'b0000};

endpackage

// File: rtl/banner_scan_ctrl_if.sv
// Buffer write port, scroll control and decoder/anode outputs of banner_scan_ctrl.
interface banner_scan_ctrl_if
    import banner_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BUF_DEPTH  = 8
);
    localparam int AW = $clog2(BUF_DEPTH);

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [ENTRY_W-1:0]    wr_data;
    logic                  scroll_en;
    logic [DIGIT_W-1:0]    bcd_digit;
    logic                  dp;
    logic [NUM_DIGITS-1:0] an;
    logic                  frame_tick;
    logic                  scroll_tick;

    modport master (
        output wr_en, wr_addr, wr_data, scroll_en,
        input  bcd_digit, dp, an, frame_tick, scroll_tick
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, scroll_en,
        output bcd_digit, dp, an, frame_tick, scroll_tick
    );

endinterface

// File: rtl/banner_tick_gen.sv
// Modulo-MOD counter with enable; wrap is high in the enabled cycle where cnt = MOD-1.
module banner_tick_gen #(
    parameter  int MOD = 4,
    localparam int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == W'(MOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/banner_scan_ctrl.sv
// Multiplexed seven-segment banner scan/scroll controller.
// Define BANNER_SCROLL_EN to build the scrolling window; otherwise slot k always shows buf[k].
module banner_scan_ctrl
    import banner_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int BUF_DEPTH     = 8,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_CYCLES  = 2,
    parameter int SCROLL_FRAMES = 250
) (
    input  logic               clk,
    input  logic               reset,
    banner_scan_ctrl_if.slave  bus
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(NUM_DIGITS);

    logic [DW-1:0]      div_cnt;
    logic               div_wrap;
    logic [SW-1:0]      slot;
    logic               slot_wrap;
    logic [AW-1:0]      offset;
    logic [AW-1:0]      rd_idx;
    logic               frame_pre;
    logic               write_arm;
    slot_state_t        state;
    logic [ENTRY_W-1:0] buf_mem [BUF_DEPTH];

    banner_tick_gen #(.MOD(REFRESH_DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .cnt   (div_cnt),
        .wrap  (div_wrap)
    );

    banner_tick_gen #(.MOD(NUM_DIGITS)) u_slot (
        .clk   (clk),
        .reset (reset),
        .en    (div_wrap),
        .cnt   (slot),
        .wrap  (slot_wrap)
    );

    // One cycle of lookahead lets the ticks be registered yet land on the frame's last cycle
    assign frame_pre = (div_cnt == DW'(REFRESH_DIV - 2)) && (slot == SW'(NUM_DIGITS - 1));
    assign rd_idx    = offset + AW'(slot);

`ifdef BANNER_SCROLL_EN
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    logic [FW-1:0] frm_cnt;
    logic          frm_wrap;
    logic          scroll_pre;

    banner_tick_gen #(.MOD(SCROLL_FRAMES)) u_frm (
        .clk   (clk),
        .reset (reset),
        .en    (slot_wrap),
        .cnt   (frm_cnt),
        .wrap  (frm_wrap)
    );

    assign scroll_pre = frame_pre && (frm_cnt == FW'(SCROLL_FRAMES - 1)) && bus.scroll_en;

    // scroll_tick is high exactly in the frm_wrap cycle, so the offset moves on the frame boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            offset          <= '0;
            bus.scroll_tick <= 1'b0;
        end else begin
            bus.scroll_tick <= scroll_pre;
            if (frm_wrap && bus.scroll_tick) begin
                offset <= offset + AW'(1);
            end
        end
    end
`else
    logic [1:0] unused_scroll;

    assign unused_scroll   = {bus.scroll_en, slot_wrap};
    assign offset          = '0;
    assign bus.scroll_tick = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_BLANK;
            bus.an         <= '1;
            bus.bcd_digit  <= '0;
            bus.dp         <= 1'b1;
            bus.frame_tick <= 1'b0;
            write_arm      <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= BLANK_ENTRY;
            end
        end else begin
            write_arm      <= 1'b1;
            bus.frame_tick <= frame_pre;
            if (bus.wr_en && write_arm) begin
                buf_mem[bus.wr_addr] <= bus.wr_data;
            end
            // The load reads buf_mem before any same-edge write lands
            case (state)
                ST_BLANK: begin
                    if (div_cnt == DW'(BLANK_CYCLES - 1)) begin
                        state                     <= ST_SHOW;
                        bus.an                    <= ~(NUM_DIGITS'(1) << slot);
                        {bus.dp, bus.bcd_digit}   <= buf_mem[rd_idx];
                    end
                end
                ST_SHOW: begin
                    if (div_wrap) begin
                        state  <= ST_BLANK;
                        bus.an <= '1;
                    end
                end
            endcase
        end
    end

endmodule
